// File: rtl/sdram_access_arbiter_pkg.sv
// rtl/sdram_access_arbiter_pkg.sv - shared widths, command and FSM encodings for the SDRAM access arbiter
package sdram_access_arbiter_pkg;

  localparam int ADDR_W = 18;
  localparam int PTR_W  = 19;
  localparam int FILL_W = 20;

  // Largest storable word count: two chips of 2^18 words each.
  localparam logic [FILL_W-1:0] FILL_MAX = 20'd524288;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_REFRESH = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sdram_ptr.sv
// rtl/sdram_ptr.sv - 19-bit {cs,addr} pointer that advances by one and wraps across both chips
module sdram_ptr
  import sdram_access_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Plain binary increment: the carry out of addr toggles cs, and {1,max} rolls to {0,0}.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register with synchronous reset to chip 0, word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sdram_access_arbiter.sv
// rtl/sdram_access_arbiter.sv - arbitrates write/read/refresh requesters onto a single SDRAM command port
module sdram_access_arbiter
  import sdram_access_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_REQ,
  input  logic              RD_REQ,
  input  logic              REF_REQ,
  input  logic              CMD_READY,
  input  logic              CMD_DONE,
  output logic              CMD_VALID,
  output logic [1:0]        CMD_OP,
  output logic              CMD_CS,
  output logic [ADDR_W-1:0] CMD_ADDR,
  output logic              WR_ACK,
  output logic              RD_ACK,
  output logic              REF_ACK,
  output logic              FULL,
  output logic              EMPTY,
  output logic [FILL_W-1:0] FILL
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_e              state_q, state_d;
  cmd_op_e             op_q, op_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  cmd_op_e             winner;
  logic                wr_elig;
  logic                rd_elig;
  logic                starved;
  logic                done_fire;
  logic                wr_adv;
  logic                rd_adv;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    cmd_ptr;

  assign FULL  = (fill_q == FILL_MAX);
  assign EMPTY = (fill_q == '0);
  assign FILL  = fill_q;

  // Pick the winner among eligible requesters: refresh, starved read, write, then read.
  always_comb begin
    wr_elig = WR_REQ && !FULL;
    rd_elig = RD_REQ && !EMPTY;
    starved = rd_elig && (starve_q == STARVE_MAX);
    winner  = OP_NONE;
    if (REF_REQ) begin
      winner = OP_REFRESH;
    end else if (starved) begin
      winner = OP_READ;
    end else if (wr_elig) begin
      winner = OP_WRITE;
    end else if (rd_elig) begin
      winner = OP_READ;
    end
  end

  // Command FSM: latch a winner in IDLE, hold it until accepted, then wait for completion.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    starve_d  = starve_q;
    done_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (winner != OP_NONE) begin
          state_d = ST_ISSUE;
          op_d    = winner;
          if (winner == OP_READ) begin
            starve_d = '0;
          end else if (winner == OP_WRITE && rd_elig && starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (CMD_READY) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (CMD_DONE) begin
          state_d = ST_IDLE;
          op_d    = OP_NONE;
          // A completion that coincides with reset belongs to a dropped command.
          done_fire = !RESET;
        end
      end
      default: begin
        state_d = ST_IDLE;
        op_d    = OP_NONE;
      end
    endcase
  end

  assign wr_adv  = done_fire && (op_q == OP_WRITE);
  assign rd_adv  = done_fire && (op_q == OP_READ);
  assign WR_ACK  = wr_adv;
  assign RD_ACK  = rd_adv;
  assign REF_ACK = done_fire && (op_q == OP_REFRESH);

  // Stored word count follows completed writes and reads only.
  always_comb begin
    fill_d = fill_q;
    if (wr_adv) begin
      fill_d = fill_q + FILL_W'(1);
    end else if (rd_adv) begin
      fill_d = fill_q - FILL_W'(1);
    end
  end

  // State, opcode, fill and starvation registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      fill_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      fill_q   <= fill_d;
      starve_q <= starve_d;
    end
  end

  sdram_ptr u_wr_ptr (
    .clk     (CLK),
    .reset   (RESET),
    .advance (wr_adv),
    .ptr     (wr_ptr)
  );

  sdram_ptr u_rd_ptr (
    .clk     (CLK),
    .reset   (RESET),
    .advance (rd_adv),
    .ptr     (rd_ptr)
  );

  // Address source follows the latched command; refresh and idle present chip 0, word 0.
  always_comb begin
    cmd_ptr = '0;
    case (op_q)
      OP_WRITE: cmd_ptr = wr_ptr;
      OP_READ:  cmd_ptr = rd_ptr;
      default:  cmd_ptr = '0;
    endcase
  end

  assign CMD_VALID = (state_q == ST_ISSUE);
  assign CMD_OP    = op_q;
  assign CMD_CS    = cmd_ptr[PTR_W-1];
  assign CMD_ADDR  = cmd_ptr[ADDR_W-1:0];

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb/tb_sdram_access_arbiter.sv - self-checking bench for sdram_access_arbiter
module tb_sdram_access_arbiter;

  localparam int LIMIT    = 4;
  localparam int FILL_TOP = 524288;
  localparam int PTR_MOD  = 524288;

  logic        clk;
  logic        reset;
  logic        wr_req, rd_req, ref_req, cmd_ready, cmd_done;
  logic        cmd_valid, cmd_cs, wr_ack, rd_ack, ref_ack, full, empty;
  logic [1:0]  cmd_op;
  logic [17:0] cmd_addr;
  logic [19:0] fill;

  int errors = 0;
  int checks = 0;

  logic [19:0] preset_fill_v;
  logic [18:0] preset_ptr_v;

  sdram_access_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK       (clk),
    .RESET     (reset),
    .WR_REQ    (wr_req),
    .RD_REQ    (rd_req),
    .REF_REQ   (ref_req),
    .CMD_READY (cmd_ready),
    .CMD_DONE  (cmd_done),
    .CMD_VALID (cmd_valid),
    .CMD_OP    (cmd_op),
    .CMD_CS    (cmd_cs),
    .CMD_ADDR  (cmd_addr),
    .WR_ACK    (wr_ack),
    .RD_ACK    (rd_ack),
    .REF_ACK   (ref_ack),
    .FULL      (full),
    .EMPTY     (empty),
    .FILL      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ack_of(input int op);
    case (op)
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    wr_req = 0; rd_req = 0; ref_req = 0; cmd_ready = 0; cmd_done = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic preset_fill(input logic [19:0] v);
    preset_fill_v = v;
    force dut.fill_q = preset_fill_v;
    @(posedge clk); #1;
    release dut.fill_q;
  endtask

  task automatic preset_wr_ptr(input logic [18:0] v);
    preset_ptr_v = v;
    force dut.u_wr_ptr.ptr_q = preset_ptr_v;
    @(posedge clk); #1;
    release dut.u_wr_ptr.ptr_q;
  endtask

  task automatic preset_rd_ptr(input logic [18:0] v);
    preset_ptr_v = v;
    force dut.u_rd_ptr.ptr_q = preset_ptr_v;
    @(posedge clk); #1;
    release dut.u_rd_ptr.ptr_q;
  endtask

  // One full transaction: raise requests, wait for a grant, accept it, complete it.
  task automatic run_cmd(input logic w, input logic r, input logic f,
                         output logic [1:0] op, output logic cs,
                         output logic [17:0] addr, output logic [2:0] acks);
    logic got;
    got = 1'b0;
    op = 2'b00; cs = 1'b0; addr = '0; acks = 3'b000;
    wr_req = w; rd_req = r; ref_req = f; cmd_ready = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (cmd_valid) got = 1'b1;
    end
    check("grant_seen", got, 1);
    if (got) begin
      op = cmd_op; cs = cmd_cs; addr = cmd_addr;
      @(posedge clk); #1;
      cmd_done = 1'b1;
      #1;
      acks = {ref_ack, rd_ack, wr_ack};
      @(posedge clk); #1;
    end
    cmd_done = 0; wr_req = 0; rd_req = 0; ref_req = 0; cmd_ready = 0;
  endtask

  typedef struct packed {
    logic [19:0] fill;
    logic        wr;
    logic        rd;
    logic        rf;
    logic        exp_valid;
    logic [1:0]  exp_op;
    logic        exp_full;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[10];

  // Transaction-level reference state
  int m_fill, m_wr_ptr, m_rd_ptr, m_starve, m_phase, m_op;
  bit req_w, req_r, req_f;

  function automatic int model_pick(input bit w, input bit r, input bit f);
    bit we, re;
    we = w && (m_fill < FILL_TOP);
    re = r && (m_fill > 0);
    if (f) return 3;
    if (re && m_starve >= LIMIT) return 2;
    if (we) return 1;
    if (re) return 2;
    return 0;
  endfunction

  initial begin
    logic [1:0]  op;
    logic        cs;
    logic [17:0] addr;
    logic [2:0]  acks;
    int          exp_order[10];
    bit          rdy, dn;
    int          win;
    int          exp_ptr;

    vecs[0] = '{20'd0,      1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[1] = '{20'd0,      1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    vecs[2] = '{20'd0,      1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[3] = '{20'd3,      1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[4] = '{20'd3,      1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
    vecs[5] = '{20'd524288, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[6] = '{20'd524288, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0};
    vecs[7] = '{20'd0,      1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    vecs[8] = '{20'd0,      1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1};
    vecs[9] = '{20'd524287, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};

    // Reset values
    do_reset();
    check("rst_valid", cmd_valid, 0);
    check("rst_op", cmd_op, 0);
    check("rst_cs", cmd_cs, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_acks", {ref_ack, rd_ack, wr_ack}, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_fill", fill, 0);

    // Arbitration table, including empty/full boundaries
    for (int i = 0; i < 10; i++) begin
      do_reset();
      preset_fill(vecs[i].fill);
      wr_req = vecs[i].wr; rd_req = vecs[i].rd; ref_req = vecs[i].rf;
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), cmd_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_op", i), cmd_op, vecs[i].exp_op);
      check($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid_hold", i), cmd_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_op_hold", i), cmd_op, vecs[i].exp_op);
    end

    // Single write with completion three cycles after the request
    do_reset();
    wr_req = 1; cmd_ready = 1;
    @(posedge clk); #1;
    check("sw_valid", cmd_valid, 1);
    check("sw_op", cmd_op, 2'b01);
    check("sw_cs", cmd_cs, 0);
    check("sw_addr", cmd_addr, 0);
    @(posedge clk); #1;
    check("sw_valid_after_accept", cmd_valid, 0);
    @(posedge clk); #1;
    check("sw_no_early_ack", wr_ack, 0);
    cmd_done = 1;
    #1;
    check("sw_ack", {ref_ack, rd_ack, wr_ack}, 3'b001);
    @(posedge clk); #1;
    cmd_done = 0; wr_req = 0; cmd_ready = 0;
    #1;
    check("sw_ack_one_pulse", wr_ack, 0);
    check("sw_fill", fill, 1);
    check("sw_empty", empty, 0);

    // Pointer wrap across chips
    do_reset();
    preset_wr_ptr(19'h3FFFF);
    run_cmd(1, 0, 0, op, cs, addr, acks);
    check("wrap0_cs", cs, 0);
    check("wrap0_addr", addr, 18'h3FFFF);
    run_cmd(1, 0, 0, op, cs, addr, acks);
    check("wrap1_cs", cs, 1);
    check("wrap1_addr", addr, 0);
    preset_wr_ptr(19'h7FFFF);
    run_cmd(1, 0, 0, op, cs, addr, acks);
    check("wrap2_cs", cs, 1);
    check("wrap2_addr", addr, 18'h3FFFF);
    run_cmd(1, 0, 0, op, cs, addr, acks);
    check("wrap3_cs", cs, 0);
    check("wrap3_addr", addr, 0);
    preset_rd_ptr(19'h3FFFF);
    run_cmd(0, 1, 0, op, cs, addr, acks);
    check("rwrap0_op", op, 2'b10);
    check("rwrap0_addr", addr, 18'h3FFFF);
    check("rwrap0_ack", acks, 3'b010);
    run_cmd(0, 1, 0, op, cs, addr, acks);
    check("rwrap1_cs", cs, 1);
    check("rwrap1_addr", addr, 0);
    check("rwrap_fill", fill, 2);

    // Starvation order with both requesters held
    do_reset();
    preset_fill(20'd5);
    exp_order = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    for (int i = 0; i < 10; i++) begin
      run_cmd(1, 1, 0, op, cs, addr, acks);
      check($sformatf("starve_grant%0d", i), op, exp_order[i]);
      check($sformatf("starve_ack%0d", i), acks, ack_of(exp_order[i]));
    end

    // Refresh wins when all three rise together
    do_reset();
    preset_fill(20'd1);
    run_cmd(1, 1, 1, op, cs, addr, acks);
    check("ref_first_op", op, 2'b11);
    check("ref_addr", {cs, addr}, 0);
    check("ref_ack", acks, 3'b100);
    check("ref_fill_unchanged", fill, 1);
    run_cmd(1, 1, 0, op, cs, addr, acks);
    check("ref_then_write", op, 2'b01);

    // Reset while waiting for completion drops the command
    do_reset();
    wr_req = 1; cmd_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_req = 0; cmd_ready = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    cmd_done = 1;
    #1;
    check("rstw_no_ack", {ref_ack, rd_ack, wr_ack}, 0);
    @(posedge clk); #1;
    cmd_done = 0;
    check("rstw_fill", fill, 0);
    check("rstw_valid", cmd_valid, 0);
    check("rstw_empty", empty, 1);
    run_cmd(1, 0, 0, op, cs, addr, acks);
    check("rstw_ptr", {cs, addr}, 0);

    // Randomized traffic against the transaction-level model
    do_reset();
    m_fill = 0; m_wr_ptr = 0; m_rd_ptr = 0; m_starve = 0; m_phase = 0; m_op = 0;
    req_w = 0; req_r = 0; req_f = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!req_w && $urandom_range(0, 2) == 0) req_w = 1;
      if (!req_r && $urandom_range(0, 2) == 0) req_r = 1;
      if (!req_f && $urandom_range(0, 15) == 0) req_f = 1;
      rdy = ($urandom_range(0, 3) != 0);
      dn  = (m_phase == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      wr_req = req_w; rd_req = req_r; ref_req = req_f; cmd_ready = rdy; cmd_done = dn;
      #1;
      check("rand_ack", {ref_ack, rd_ack, wr_ack},
            (m_phase == 2 && dn) ? ack_of(m_op) : 3'b000);
      @(posedge clk); #1;
      case (m_phase)
        0: begin
          win = model_pick(req_w, req_r, req_f);
          if (win != 0) begin
            if (win == 2) m_starve = 0;
            else if (win == 1 && req_r && m_fill > 0 && m_starve < LIMIT) m_starve++;
            m_op = win;
            m_phase = 1;
          end
        end
        1: if (rdy) m_phase = 2;
        default: begin
          if (dn) begin
            if (m_op == 1) begin
              m_fill++; m_wr_ptr = (m_wr_ptr + 1) % PTR_MOD; req_w = 0;
            end else if (m_op == 2) begin
              m_fill--; m_rd_ptr = (m_rd_ptr + 1) % PTR_MOD; req_r = 0;
            end else begin
              req_f = 0;
            end
            m_phase = 0;
          end
        end
      endcase
      check("rand_valid", cmd_valid, (m_phase == 1) ? 1 : 0);
      if (m_phase == 1) begin
        check("rand_op", cmd_op, m_op);
        exp_ptr = (m_op == 1) ? m_wr_ptr : (m_op == 2) ? m_rd_ptr : 0;
        check("rand_cs_addr", {cmd_cs, cmd_addr}, exp_ptr);
      end
      check("rand_fill", fill, m_fill);
      check("rand_empty", empty, (m_fill == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
